// File: rtl/fetch_unit.sv
// Instruction fetch: walks a word-aligned PC, keeps at most one memory request
// in flight and hands each returned word to decode through a valid/ready register.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DROP
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [29:0] pc_word;
    logic [29:0] pc_next;
    logic [29:0] req_word;
    logic        req_fire;
    logic        id_fire;
    logic        load_id;
    logic        unused_redirect_low;

    // The PC is stored as a word index so its two low bits cannot become non-zero.
    assign imem_req_valid      = (state == S_REQ) && !id_valid && !rst;
    assign imem_req_addr       = {pc_word, 2'b00};
    assign req_fire            = imem_req_valid && imem_req_ready;
    assign id_fire             = id_valid && id_ready;
    assign load_id             = (state == S_WAIT) && imem_rsp_valid && !redirect_valid;
    assign unused_redirect_low = ^redirect_pc[1:0];

    always_comb begin
        state_next = state;
        pc_next    = pc_word;
        case (state)
            S_REQ: begin
                if (req_fire) begin
                    state_next = redirect_valid ? S_DROP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    state_next = S_REQ;
                end else if (redirect_valid) begin
                    state_next = S_DROP;
                end
            end
            S_DROP: begin
                // A response landing with a redirect still retires the doomed request.
                if (imem_rsp_valid) begin
                    state_next = S_REQ;
                end
            end
            default: state_next = S_REQ;
        endcase

        if (redirect_valid) begin
            pc_next = redirect_pc[31:2];
        end else if (req_fire) begin
            pc_next = pc_word + 30'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_REQ;
            pc_word  <= RESET_PC[31:2];
            req_word <= '0;
        end else begin
            state   <= state_next;
            pc_word <= pc_next;
            if (req_fire) begin
                req_word <= pc_word;
            end
        end
    end

    // Decode register: a redirect flushes it, a live response loads it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid <= 1'b0;
            id_instr <= '0;
            id_pc    <= '0;
        end else begin
            if (redirect_valid) begin
                id_valid <= 1'b0;
            end else if (load_id) begin
                id_valid <= 1'b1;
            end else if (id_fire) begin
                id_valid <= 1'b0;
            end
            if (load_id) begin
                id_instr <= imem_rsp_data;
                id_pc    <= {req_word, 2'b00};
            end
        end
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Ports, clock and reset first; the design SHALL use one clock, and reset SHALL be asynchronous and active-high:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request
- imem_req_addr  output  32  fetch address, word-aligned
- imem_rsp_valid  input  1  instruction word returned
- imem_rsp_data  input  32  instruction word
- redirect_valid  input  1  taken branch/jump, single-cycle pulse from execute
- redirect_pc  input  32  new fetch target
- id_valid  output  1  instruction available to decode
- id_ready  input  1  decode accepts instruction
- id_instr  output  32  fetched instruction
- id_pc  output  32  address of id_instr

Function
REQ-003 The block SHALL keep a fetch PC and an FSM with states REQ, WAIT and DROP, with at most one outstanding memory request.
REQ-004 imem_req_valid SHALL be 1 only in REQ with id_valid=0, and imem_req_addr SHALL equal the PC.
REQ-005 While imem_req_valid=1 and imem_req_ready=0, imem_req_addr SHALL hold stable.
REQ-006 On request acceptance (valid&ready), the block SHALL latch the request address, set PC = PC+4 (mod 2^32, so 32'hFFFF_FFFC wraps to 0), and go to WAIT.
REQ-007 In WAIT with imem_rsp_valid=1, the block SHALL go to REQ next cycle with id_valid=1, id_instr=imem_rsp_data and id_pc=latched request address (response latency to id_valid: 1 cycle).
REQ-008 imem_rsp_valid in REQ SHALL be ignored.
REQ-009 id_valid, id_instr and id_pc SHALL hold until id_valid&id_ready; on that handshake id_valid SHALL clear next cycle unless REQ-007 reloads it in the same cycle.
REQ-010 Redirect SHALL have priority over every other event: PC <= {redirect_pc[31:2],2'b00} and id_valid <= 0 (flush).
REQ-011 Redirect in WAIT without a same-cycle response SHALL go to DROP.
REQ-012 Redirect in WAIT with a same-cycle response SHALL discard the response and go to REQ.
REQ-013 Redirect in the same cycle as a request acceptance SHALL go to DROP, and the PC SHALL take the redirect target, not PC+4.
REQ-014 Redirect in REQ without acceptance SHALL stay in REQ, and the new address SHALL appear on imem_req_addr next cycle.
REQ-015 In DROP, imem_rsp_valid SHALL discard the response and go to REQ, id_valid SHALL stay 0, and imem_req_valid SHALL stay 0.
REQ-016 Redirect in DROP SHALL update the PC and stay in DROP.
REQ-017 PC bits [1:0] and imem_req_addr bits [1:0] SHALL always be 0.

Reset
REQ-018 While rst=1, the block SHALL set state=REQ, PC=RESET_PC, imem_req_valid=0, id_valid=0, id_instr=0, id_pc=0, and clear any outstanding request.
REQ-019 Reset asserted mid-WAIT or mid-DROP SHALL abandon the transaction, and any response arriving after rst deasserts SHALL be ignored until the first post-reset request is accepted.
REQ-020 The first request SHALL assert in the first cycle after rst deasserts, with imem_req_addr=RESET_PC.

Verification
REQ-021 Reset release, ready=1, 1-cycle memory returning 32'h0000_0013, id_ready=1 -> requests at 0x0, 0x4, 0x8; each id_pc matches its request address; id_instr=32'h13.
REQ-022 imem_req_ready=0 for 3 cycles at PC 0x10 -> imem_req_addr holds 0x10 throughout; PC becomes 0x14 only after acceptance.
REQ-023 id_ready=0 for 4 cycles with an instruction at 0x8 -> id_valid, id_instr and id_pc stable; no new request issued until the handshake.
REQ-024 Redirect to 0x0000_0102 while WAIT for 0x20, response 2 cycles later -> DROP; response discarded; next request at 0x100; id never presents 0x20.
REQ-025 Redirect to 0x40 in the same cycle as a response for 0x24 -> response discarded; id_valid=0; next request at 0x40.
REQ-026 PC at 0xFFFF_FFFC accepted -> next request at 0x0000_0000; rst pulse mid-WAIT -> next request at RESET_PC, and the stale response is ignored.
